// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_controller
// Description : 640x480@60 VGA scan timing on a half-rate pixel enable, with
//               a Tetris board renderer (cells, white border) and
//               colour/sync pipelined together over two pixel ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_controller #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int BOARD_X0   = 220,
    parameter int BOARD_Y0   = 40,
    parameter int CELL_SIZE  = 20,
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] cell_data,
    output logic [7:0] cell_addr,
    output logic       cell_rd,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       vblank
);

    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int C_BOARD_W = CELL_SIZE * BOARD_COLS;
    localparam int C_BOARD_H = CELL_SIZE * BOARD_ROWS;

    localparam logic [9:0] C_H_LAST   = 10'(C_H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST   = 10'(C_V_TOTAL - 1);
    localparam logic [9:0] C_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] C_BX0      = 10'(BOARD_X0);
    localparam logic [9:0] C_BX1      = 10'(BOARD_X0 + C_BOARD_W);
    localparam logic [9:0] C_BY0      = 10'(BOARD_Y0);
    localparam logic [9:0] C_BY1      = 10'(BOARD_Y0 + C_BOARD_H);
    localparam logic [9:0] C_BX_PRE   = 10'(BOARD_X0 - 1);
    localparam logic [9:0] C_BY_PRE   = 10'(BOARD_Y0 - 1);
    localparam logic [9:0] C_RX0      = 10'(BOARD_X0 - 2);
    localparam logic [9:0] C_RX1      = 10'(BOARD_X0 + C_BOARD_W + 2);
    localparam logic [9:0] C_RY0      = 10'(BOARD_Y0 - 2);
    localparam logic [9:0] C_RY1      = 10'(BOARD_Y0 + C_BOARD_H + 2);
    localparam logic [4:0] C_SUB_LAST = 5'(CELL_SIZE - 1);
    localparam logic [7:0] C_COLS     = 8'(BOARD_COLS);

    // Stage 0: pixel enable, scan counters and incremental cell position
    logic       r_phase;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [4:0] r_sub_x;
    logic [7:0] r_col;
    logic [4:0] r_sub_y;
    logic [7:0] r_row_base;

    // Stage 1
    logic       r_s1_active;
    logic       r_s1_board;
    logic       r_s1_border;
    logic       r_s1_hs;
    logic       r_s1_vs;
    logic [7:0] r_cell_addr;
    logic       r_cell_rd;

    // Stage 2
    logic       r_R;
    logic       r_G;
    logic       r_B;
    logic       r_hs;
    logic       r_vs;
    logic       r_frame_start;

    logic       w_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_in_bx;
    logic       w_in_by;
    logic       w_in_board;
    logic       w_in_ring;
    logic       w_active;
    logic       w_hs_n;
    logic       w_vs_n;
    logic [7:0] w_cell_idx;
    logic [2:0] w_pix;

    assign w_tick     = r_phase;
    assign w_h_wrap   = (r_h_cnt == C_H_LAST);
    assign w_v_wrap   = (r_v_cnt == C_V_LAST);
    assign w_in_bx    = (r_h_cnt >= C_BX0) && (r_h_cnt < C_BX1);
    assign w_in_by    = (r_v_cnt >= C_BY0) && (r_v_cnt < C_BY1);
    assign w_in_board = w_in_bx && w_in_by;
    assign w_in_ring  = (r_h_cnt >= C_RX0) && (r_h_cnt < C_RX1) &&
                        (r_v_cnt >= C_RY0) && (r_v_cnt < C_RY1);
    assign w_active   = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    assign w_hs_n     = !((r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END));
    assign w_vs_n     = !((r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END));
    assign w_cell_idx = r_row_base + r_col;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_phase <= 1'b0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (w_tick) begin
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    // Cell position tracks the stage-0 pixel; re-armed one pixel/line ahead
    // of the board so the first board pixel always sees cell 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sub_x    <= '0;
            r_col      <= '0;
            r_sub_y    <= '0;
            r_row_base <= '0;
        end else if (w_tick) begin
            if (r_h_cnt == C_BX_PRE) begin
                r_sub_x <= '0;
                r_col   <= '0;
            end else if (w_in_bx) begin
                if (r_sub_x == C_SUB_LAST) begin
                    r_sub_x <= '0;
                    r_col   <= r_col + 8'd1;
                end else begin
                    r_sub_x <= r_sub_x + 5'd1;
                end
            end
            if (w_h_wrap) begin
                if (r_v_cnt == C_BY_PRE) begin
                    r_sub_y    <= '0;
                    r_row_base <= '0;
                end else if (w_in_by) begin
                    if (r_sub_y == C_SUB_LAST) begin
                        r_sub_y    <= '0;
                        r_row_base <= r_row_base + C_COLS;
                    end else begin
                        r_sub_y <= r_sub_y + 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_active <= 1'b0;
            r_s1_board  <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_cell_addr <= '0;
            r_cell_rd   <= 1'b0;
        end else if (w_tick) begin
            r_s1_active <= w_active;
            r_s1_board  <= w_in_board;
            r_s1_border <= w_in_ring && !w_in_board;
            r_s1_hs     <= w_hs_n;
            r_s1_vs     <= w_vs_n;
            r_cell_rd   <= w_in_board;
            if (w_in_board) begin
                r_cell_addr <= w_cell_idx;
            end
        end
    end

    // Board memory answers one clk after the stage-1 address, so cell_data
    // is already valid when stage 2 samples it on the following tick.
    always_comb begin
        w_pix = 3'b000;
        if (r_s1_active) begin
            if (r_s1_board) begin
                w_pix = cell_data;
            end else if (r_s1_border) begin
                w_pix = 3'b111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_R           <= 1'b0;
            r_G           <= 1'b0;
            r_B           <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
            if (w_tick) begin
                r_R  <= w_pix[2];
                r_G  <= w_pix[1];
                r_B  <= w_pix[0];
                r_hs <= r_s1_hs;
                r_vs <= r_s1_vs;
            end
        end
    end

    assign cell_addr   = r_cell_addr;
    assign cell_rd     = r_cell_rd;
    assign R           = r_R;
    assign G           = r_G;
    assign B           = r_B;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_frame_start;
    assign vblank      = (r_v_cnt >= C_V_ACT);

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_controller
// Description : Bench for vga_scan_controller: a full-size instance plus a
//               shrunken-geometry instance, both compared against a pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_controller;

    typedef struct packed {
        int hact; int hfp; int hsync; int hbp;
        int vact; int vfp; int vsync; int vbp;
        int bx; int by; int cs; int cols; int rows;
    } cfg_t;

    typedef struct packed { int h; int v; int kind; int val; } pt_t;

    logic       clk = 1'b0;
    logic       resetn_a, resetn_b;
    logic [2:0] cd_a, cd_b;
    logic [7:0] addr_a, addr_b;
    logic       rd_a, rd_b, r_a, r_b, g_a, g_b, b_a, b_b;
    logic       hs_a, hs_b, vs_a, vs_b, fs_a, fs_b, vb_a, vb_b;

    logic [2:0] mem [0:255];
    cfg_t       cfg_a, cfg_b;
    pt_t        pts [11];

    int checks = 0;
    int errors = 0;
    int na = 0, nb = 0;
    int exp_addr_a = 0, exp_addr_b = 0;
    int a_fall = -1, b_vfall = -1, b_fs = 0;
    logic a_prev_hs = 1'b1, b_prev_vs = 1'b1;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cd_a <= mem[addr_a];
        cd_b <= mem[addr_b];
    end

    vga_scan_controller u_dut_a (
        .clk(clk), .resetn(resetn_a), .cell_data(cd_a),
        .cell_addr(addr_a), .cell_rd(rd_a), .R(r_a), .G(g_a), .B(b_a),
        .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .vblank(vb_a)
    );

    vga_scan_controller #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(96), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .BOARD_X0(10), .BOARD_Y0(4), .CELL_SIZE(4), .BOARD_COLS(10), .BOARD_ROWS(20)
    ) u_dut_b (
        .clk(clk), .resetn(resetn_b), .cell_data(cd_b),
        .cell_addr(addr_b), .cell_rd(rd_b), .R(r_b), .G(g_b), .B(b_b),
        .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .vblank(vb_b)
    );

    function automatic bit in_board(cfg_t c, int h, int v);
        return h >= c.bx && h < c.bx + c.cols * c.cs && v >= c.by && v < c.by + c.rows * c.cs;
    endfunction

    function automatic bit in_ring(cfg_t c, int h, int v);
        return h >= c.bx - 2 && h < c.bx + c.cols * c.cs + 2 &&
               v >= c.by - 2 && v < c.by + c.rows * c.cs + 2;
    endfunction

    function automatic int cell_of(cfg_t c, int h, int v);
        return ((v - c.by) / c.cs) * c.cols + (h - c.bx) / c.cs;
    endfunction

    function automatic logic [2:0] rgb_of(cfg_t c, int h, int v);
        if (h >= c.hact || v >= c.vact) return 3'b000;
        if (in_board(c, h, v)) return mem[cell_of(c, h, v)];
        if (in_ring(c, h, v)) return 3'b111;
        return 3'b000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // n = clocks since the last clock edge that sampled reset low
    task automatic check_dut(input string tag, input cfg_t c, input int n,
                             input logic [2:0] rgb, input logic hs, input logic vs,
                             input logic rd, input logic [7:0] addr, input logic fs,
                             input logic vb, input int prev_addr, output int next_addr);
        int ht, fr, p, h, v;
        logic [2:0] e_rgb;
        logic e_hs, e_vs, e_rd, e_vb, e_fs;
        ht = c.hact + c.hfp + c.hsync + c.hbp;
        fr = ht * (c.vact + c.vfp + c.vsync + c.vbp);
        e_rgb = 3'b000; e_hs = 1'b1; e_vs = 1'b1;
        if (n >= 4) begin
            p = (n / 2 - 2) % fr; h = p % ht; v = p / ht;
            e_rgb = rgb_of(c, h, v);
            e_hs = !(h >= c.hact + c.hfp && h < c.hact + c.hfp + c.hsync);
            e_vs = !(v >= c.vact + c.vfp && v < c.vact + c.vfp + c.vsync);
        end
        e_rd = 1'b0;
        next_addr = (n < 2) ? 0 : prev_addr;
        if (n >= 2) begin
            p = (n / 2 - 1) % fr; h = p % ht; v = p / ht;
            e_rd = in_board(c, h, v);
            if (e_rd) next_addr = cell_of(c, h, v);
        end
        p = (n / 2) % fr; v = p / ht;
        e_vb = (v >= c.vact);
        e_fs = (n > 0) && (n % (2 * fr) == 0);
        check_eq({tag, ".rgb"}, 32'(rgb), 32'(e_rgb));
        check_eq({tag, ".hs"}, 32'(hs), 32'(e_hs));
        check_eq({tag, ".vs"}, 32'(vs), 32'(e_vs));
        check_eq({tag, ".cell_rd"}, 32'(rd), 32'(e_rd));
        check_eq({tag, ".cell_addr"}, 32'(addr), 32'(next_addr));
        check_eq({tag, ".frame_start"}, 32'(fs), 32'(e_fs));
        check_eq({tag, ".vblank"}, 32'(vb), 32'(e_vb));
    endtask

    // Named boundary pixels on the full-size instance, each hit once per tick
    task automatic check_points();
        int p1, p2;
        if (na >= 4 && na % 2 == 0) begin
            p1 = na / 2 - 1;
            p2 = na / 2 - 2;
            foreach (pts[i]) begin
                if (pts[i].kind == 0 && p1 == pts[i].v * 800 + pts[i].h)
                    check_eq($sformatf("pt_addr(%0d,%0d)", pts[i].h, pts[i].v), 32'(addr_a), pts[i].val);
                if (pts[i].kind == 1 && p1 == pts[i].v * 800 + pts[i].h)
                    check_eq($sformatf("pt_rd(%0d,%0d)", pts[i].h, pts[i].v), 32'(rd_a), pts[i].val);
                if (pts[i].kind == 2 && p2 == pts[i].v * 800 + pts[i].h)
                    check_eq($sformatf("pt_rgb(%0d,%0d)", pts[i].h, pts[i].v), 32'({r_a, g_a, b_a}), pts[i].val);
            end
        end
    endtask

    task automatic track_sync();
        if (na == 0) begin
            a_fall = -1; a_prev_hs = 1'b1;
        end else begin
            if (a_prev_hs && !hs_a) begin
                if (a_fall < 0) check_eq("hs_first_fall", na, 656 * 2 + 4);
                else            check_eq("hs_period", na - a_fall, 1600);
                a_fall = na;
            end
            if (!a_prev_hs && hs_a && a_fall >= 0) check_eq("hs_low", na - a_fall, 192);
            a_prev_hs = hs_a;
        end
        if (nb == 0) begin
            b_vfall = -1; b_fs = 0; b_prev_vs = 1'b1;
        end else begin
            if (fs_b === 1'b1) b_fs++;
            if (b_prev_vs && !vs_b) begin
                if (b_vfall >= 0) begin
                    check_eq("vs_period", nb - b_vfall, 2 * 80 * 103);
                    check_eq("fs_per_frame", b_fs, 1);
                end
                b_vfall = nb; b_fs = 0;
            end
            if (!b_prev_vs && vs_b && b_vfall >= 0) check_eq("vs_low", nb - b_vfall, 2 * 80 * 2);
            b_prev_vs = vs_b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        na = resetn_a ? na + 1 : 0;
        nb = resetn_b ? nb + 1 : 0;
        @(negedge clk);
        check_dut("a", cfg_a, na, {r_a, g_a, b_a}, hs_a, vs_a, rd_a, addr_a, fs_a, vb_a, exp_addr_a, exp_addr_a);
        check_dut("b", cfg_b, nb, {r_b, g_b, b_b}, hs_b, vs_b, rd_b, addr_b, fs_b, vb_b, exp_addr_b, exp_addr_b);
        check_points();
        track_sync();
    endtask

    initial begin
        cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 220, 40, 20, 10, 20};
        cfg_b = '{64, 4, 8, 4, 96, 2, 2, 3, 10, 4, 4, 10, 20};
        pts[0]  = '{220, 40, 0, 0};
        pts[1]  = '{239, 40, 0, 0};
        pts[2]  = '{240, 40, 0, 1};
        pts[3]  = '{219, 40, 1, 0};
        pts[4]  = '{420, 40, 1, 0};
        pts[5]  = '{220, 40, 1, 1};
        pts[6]  = '{218, 38, 2, 7};
        pts[7]  = '{217, 38, 2, 0};
        pts[8]  = '{220, 40, 2, 5};
        pts[9]  = '{240, 40, 2, 2};
        pts[10] = '{700, 20, 2, 0};
        for (int i = 0; i < 256; i++) mem[i] = 3'($urandom);
        mem[0] = 3'b101;
        mem[1] = 3'b010;

        resetn_a = 1'b0; resetn_b = 1'b0;
        repeat (3) step();
        resetn_a = 1'b1; resetn_b = 1'b1;
        repeat ($urandom_range(2000, 3200)) step();

        // mid-frame reset: 5 clk on the full-size instance, random on the other
        resetn_a = 1'b0; resetn_b = 1'b0;
        repeat (5) step();
        resetn_a = 1'b1;
        repeat ($urandom_range(1, 7)) step();
        resetn_b = 1'b1;
        repeat ($urandom_range(9000, 18000)) step();

        resetn_b = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        resetn_b = 1'b1;
        while (na < 64900) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
